// File: rtl/seg_pkg.sv
// Shared definitions for the scanned 7-segment display path: segment
// patterns (active-high, bit 0 = segment a), the blank pattern, and the
// per-digit record held in the pending and active display buffers.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // All segments dark, before any polarity inversion.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One digit of a display buffer.
  typedef struct packed {
    logic [3:0] data;
    logic       dp;
    logic       blank;
    logic       blink;
  } disp_digit_t;

  // Buffer contents after reset: every digit blanked so nothing shows
  // until real data has been loaded and promoted at a frame boundary.
  localparam disp_digit_t DIGIT_CLEAR = '{data: 4'h0, dp: 1'b0, blank: 1'b1, blink: 1'b0};

  // Standard hex-to-segment decode, active-high.
  function automatic logic [6:0] hex_pattern(input logic [3:0] nibble);
    logic [6:0] pat;
    pat = SEG_BLANK;
    case (nibble)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      4'hF: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Load port of the display driver: per-digit nibbles and masks captured
// by a one-cycle load strobe, plus the live brightness level.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 3
) ();

  logic                    load;
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [BRIGHT_W-1:0]     brightness;

  // Formatting logic drives the port.
  modport master (
    output load, digit_data, dp_mask, blank_mask, blink_mask, brightness
  );

  // The display driver consumes it.
  modport slave (
    input load, digit_data, dp_mask, blank_mask, blink_mask, brightness
  );

endinterface

// File: rtl/seg_scan_mux_hex_to_7seg.sv
// Purely combinational hex digit to 7-segment decoder. Output is
// active-high; pin polarity is handled by the scanning driver.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Table lookup of the standard 0-F segment patterns.
  always_comb begin
    o_seg = hex_pattern(i_nibble);
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Scanning driver for a multi-digit common-anode 7-segment display.
// Display data is double-buffered: a load fills the pending buffer and
// the pending buffer is promoted to the active buffer at each frame
// boundary, so a digit never changes mid-frame. Each digit slot starts
// with one dead cycle to suppress ghosting, and a PWM gate taken from
// the top bits of the slot counter sets the brightness.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 8,
  parameter int SCAN_W           = 10,
  parameter int BRIGHT_W         = 3,
  parameter int BLINK_FRAMES     = 64,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_mux_if.slave         bus,
  output logic [6:0]            seg_cathode,
  output logic                  seg_dp,
  output logic [NUM_DIGITS-1:0] seg_anode,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0]      LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]       LAST_FRAME = FC_W'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_INV    = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_INV     = SEG_ACTIVE_LOW;

  // Scan position and blink timing.
  logic [SCAN_W-1:0] r_slot_cnt;
  logic [IDX_W-1:0]  r_dig_idx;
  logic [FC_W-1:0]   r_frame_cnt;
  logic              r_blink_phase;

  // Double-buffered display contents.
  disp_digit_t [NUM_DIGITS-1:0] r_pending;
  disp_digit_t [NUM_DIGITS-1:0] r_active;

  // Registered pin drivers.
  logic [6:0]            r_seg_cathode;
  logic                  r_seg_dp;
  logic [NUM_DIGITS-1:0] r_seg_anode;
  logic                  r_frame_done;

  logic                         w_slot_term;
  logic                         w_frame_bound;
  disp_digit_t [NUM_DIGITS-1:0] w_load_rec;
  disp_digit_t                  w_cur;
  logic [6:0]                   w_pattern;
  logic [BRIGHT_W-1:0]          w_pwm_level;
  logic                         w_pwm_open;
  logic                         w_lit;
  logic [NUM_DIGITS-1:0]        w_onehot;
  logic [NUM_DIGITS-1:0]        w_anode_next;
  logic [6:0]                   w_cathode_next;
  logic                         w_dp_next;

  assign w_slot_term   = &r_slot_cnt;
  assign w_frame_bound = w_slot_term && (r_dig_idx == LAST_DIGIT);

  // Repack the flat load-port vectors into per-digit records.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_load_rec
    assign w_load_rec[g] = {bus.digit_data[4*g +: 4], bus.dp_mask[g],
                            bus.blank_mask[g], bus.blink_mask[g]};
  end

  // Slot counter runs freely; the digit index steps at each slot's end
  // and wraps after the last digit, which defines the frame boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot_cnt <= '0;
      r_dig_idx  <= '0;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
      if (w_slot_term) begin
        if (r_dig_idx == LAST_DIGIT) begin
          r_dig_idx <= '0;
        end else begin
          r_dig_idx <= r_dig_idx + 1'b1;
        end
      end
    end
  end

  // Count frames and flip the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_bound) begin
      if (r_frame_cnt == LAST_FRAME) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // Load fills pending; a frame boundary promotes the pre-edge pending
  // contents, so a load coinciding with the boundary shows a frame later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= {NUM_DIGITS{DIGIT_CLEAR}};
      r_active  <= {NUM_DIGITS{DIGIT_CLEAR}};
    end else begin
      if (bus.load) begin
        r_pending <= w_load_rec;
      end
      if (w_frame_bound) begin
        r_active <= r_pending;
      end
    end
  end

  assign w_cur = r_active[r_dig_idx];

  hex_to_7seg u_decode (
    .i_nibble (w_cur.data),
    .o_seg    (w_pattern)
  );

  // Decide whether the current digit is lit and form the next pin values.
  always_comb begin
    w_onehot            = '0;
    w_onehot[r_dig_idx] = 1'b1;
    w_pwm_level         = r_slot_cnt[SCAN_W-1 -: BRIGHT_W];
    w_pwm_open          = (w_pwm_level < bus.brightness) || (&bus.brightness);
    w_lit               = (r_slot_cnt != '0) && !w_cur.blank &&
                          !(w_cur.blink && r_blink_phase) && w_pwm_open;
    w_anode_next        = ANODE_OFF;
    w_cathode_next      = SEG_BLANK ^ SEG_INV;
    w_dp_next           = DP_INV;
    if (w_lit) begin
      w_anode_next   = w_onehot ^ ANODE_OFF;
      w_cathode_next = w_pattern ^ SEG_INV;
      w_dp_next      = w_cur.dp ^ DP_INV;
    end
  end

  // Register every pin so nothing reaches the board combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg_anode   <= ANODE_OFF;
      r_seg_cathode <= SEG_BLANK ^ SEG_INV;
      r_seg_dp      <= DP_INV;
      r_frame_done  <= 1'b0;
    end else begin
      r_seg_anode   <= w_anode_next;
      r_seg_cathode <= w_cathode_next;
      r_seg_dp      <= w_dp_next;
      r_frame_done  <= w_frame_bound;
    end
  end

  assign seg_anode   = r_seg_anode;
  assign seg_cathode = r_seg_cathode;
  assign seg_dp      = r_seg_dp;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with 4 digits, 16-cycle slots,
// 2-bit brightness and a 2-frame blink half-period.
module tb_seg_scan_mux;

  localparam int ND = 4;
  localparam int SW = 4;
  localparam int BW = 2;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] seg_cathode;
  logic       seg_dp;
  logic [3:0] seg_anode;
  logic       frame_done;

  int asserts    = 0;
  int fails      = 0;
  int boundaries = 0;

  logic [6:0] pat [16];

  seg_scan_mux_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus_if ();

  seg_scan_mux #(
    .NUM_DIGITS       (ND),
    .SCAN_W           (SW),
    .BRIGHT_W         (BW),
    .BLINK_FRAMES     (BF),
    .ANODE_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .seg_cathode (seg_cathode),
    .seg_dp      (seg_dp),
    .seg_anode   (seg_anode),
    .frame_done  (frame_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run still active at time limit, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] data, input logic [3:0] dpm,
                         input logic [3:0] bnk, input logic [3:0] blk);
    bus_if.digit_data = data;
    bus_if.dp_mask    = dpm;
    bus_if.blank_mask = bnk;
    bus_if.blink_mask = blk;
    bus_if.load       = 1'b1;
    step();
    bus_if.load       = 1'b0;
  endtask

  task automatic wait_boundary(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      step();
      if (frame_done === 1'b1) seen = 1'b1;
    end
    asserts++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL %s: frame_done absent for 200 cycles, required a pulse", name);
    end else begin
      boundaries++;
    end
  endtask

  // Entered on a frame_done cycle; checks every pin of the following
  // 64 cycles against the display rules, ending on the next frame_done.
  task automatic check_frame(input string name, input logic [15:0] data,
                             input logic [3:0] dpm, input logic [3:0] bnk,
                             input logic [3:0] blk);
    bit         phase;
    bit         lit;
    int         s;
    int         d;
    logic [1:0] br;
    logic [3:0] nib;
    logic [3:0] ea;
    logic [6:0] ec;
    logic       edp;
    logic       efd;
    phase = boundaries[1];
    for (int k = 1; k <= 64; k++) begin
      step();
      br  = bus_if.brightness;
      s   = (k - 1) % 16;
      d   = (k - 1) / 16;
      nib = data[4*d +: 4];
      lit = (s != 0) && !bnk[d] && !(blk[d] && phase) &&
            (((s / 4) < int'(br)) || (br == 2'b11));
      ea  = lit ? ~(4'b0001 << d) : 4'b1111;
      ec  = lit ? ~pat[nib] : 7'h7F;
      edp = lit ? ~dpm[d] : 1'b1;
      efd = (k == 64);
      asserts++;
      if (seg_anode !== ea) begin
        fails++;
        $display("[TB] FAIL %s anode k=%0d: got %b, expected %b", name, k, seg_anode, ea);
      end
      asserts++;
      if (seg_cathode !== ec) begin
        fails++;
        $display("[TB] FAIL %s cathode k=%0d: got %b, expected %b", name, k, seg_cathode, ec);
      end
      asserts++;
      if (seg_dp !== edp) begin
        fails++;
        $display("[TB] FAIL %s dp k=%0d: got %b, expected %b", name, k, seg_dp, edp);
      end
      asserts++;
      if (frame_done !== efd) begin
        fails++;
        $display("[TB] FAIL %s frame_done k=%0d: got %b, expected %b", name, k, frame_done, efd);
      end
    end
    boundaries++;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) step();
    asserts++;
    if (seg_anode !== 4'b1111) begin
      fails++;
      $display("[TB] FAIL reset_anode: got %b, expected 1111", seg_anode);
    end
    asserts++;
    if (seg_cathode !== 7'h7F) begin
      fails++;
      $display("[TB] FAIL reset_cathode: got %h, expected 7f", seg_cathode);
    end
    asserts++;
    if (seg_dp !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_dp: got %b, expected 1", seg_dp);
    end
    asserts++;
    if (frame_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_frame_done: got %b, expected 0", frame_done);
    end
    rst        = 1'b1;
    boundaries = 0;
    repeat (3) check_frame("reset_dark", 16'h0000, 4'h0, 4'hF, 4'h0);
  endtask

  task automatic test_load_display;
    repeat (5) step();
    do_load(16'h1234, 4'h0, 4'h0, 4'h0);
    wait_boundary("load_boundary");
    step();
    asserts++;
    if (seg_anode !== 4'b1111) begin
      fails++;
      $display("[TB] FAIL dead_time_anode: got %b, expected 1111", seg_anode);
    end
    step();
    asserts++;
    if (seg_anode !== 4'b1110) begin
      fails++;
      $display("[TB] FAIL digit0_anode: got %b, expected 1110", seg_anode);
    end
    asserts++;
    if (seg_cathode !== 7'b0011001) begin
      fails++;
      $display("[TB] FAIL digit0_cathode: got %b, expected 0011001", seg_cathode);
    end
    asserts++;
    if (seg_dp !== 1'b1) begin
      fails++;
      $display("[TB] FAIL digit0_dp: got %b, expected 1", seg_dp);
    end
    repeat (62) step();
    asserts++;
    if (frame_done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL frame_period: frame_done got %b, expected 1", frame_done);
    end
    boundaries++;
    check_frame("digits_1234", 16'h1234, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic test_boundary_load;
    repeat (5) step();
    do_load(16'h9876, 4'b0100, 4'h0, 4'h0);
    repeat (57) step();
    bus_if.digit_data = 16'hABCD;
    bus_if.dp_mask    = 4'h0;
    bus_if.blank_mask = 4'h0;
    bus_if.blink_mask = 4'h0;
    bus_if.load       = 1'b1;
    step();
    bus_if.load       = 1'b0;
    asserts++;
    if (frame_done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL boundary_load_align: frame_done got %b, expected 1", frame_done);
    end
    boundaries++;
    check_frame("old_pending", 16'h9876, 4'b0100, 4'h0, 4'h0);
    check_frame("new_pending", 16'hABCD, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic test_brightness;
    bus_if.brightness = 2'd1;
    check_frame("bright_1", 16'hABCD, 4'h0, 4'h0, 4'h0);
    bus_if.brightness = 2'd0;
    check_frame("bright_0", 16'hABCD, 4'h0, 4'h0, 4'h0);
    bus_if.brightness = 2'd3;
  endtask

  task automatic test_blink;
    repeat (5) step();
    do_load(16'h5678, 4'h0, 4'h0, 4'b0010);
    wait_boundary("blink_boundary");
    repeat (4) check_frame("blink", 16'h5678, 4'h0, 4'h0, 4'b0010);
  endtask

  task automatic test_reset_midframe;
    repeat (40) step();
    asserts++;
    if (seg_anode !== 4'b1011) begin
      fails++;
      $display("[TB] FAIL pre_reset_anode: got %b, expected 1011", seg_anode);
    end
    asserts++;
    if (seg_cathode !== 7'h02) begin
      fails++;
      $display("[TB] FAIL pre_reset_cathode: got %h, expected 02", seg_cathode);
    end
    rst = 1'b0;
    #1;
    asserts++;
    if (seg_anode !== 4'b1111) begin
      fails++;
      $display("[TB] FAIL async_reset_anode: got %b, expected 1111", seg_anode);
    end
    asserts++;
    if (seg_cathode !== 7'h7F) begin
      fails++;
      $display("[TB] FAIL async_reset_cathode: got %h, expected 7f", seg_cathode);
    end
    asserts++;
    if (seg_dp !== 1'b1) begin
      fails++;
      $display("[TB] FAIL async_reset_dp: got %b, expected 1", seg_dp);
    end
    asserts++;
    if (frame_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset_frame_done: got %b, expected 0", frame_done);
    end
    repeat (2) step();
    rst        = 1'b1;
    boundaries = 0;
    check_frame("post_reset_dark", 16'h0000, 4'h0, 4'hF, 4'h0);
    repeat (3) step();
    do_load(16'h0F0E, 4'b1000, 4'h0, 4'h0);
    wait_boundary("reload_boundary");
    check_frame("reload", 16'h0F0E, 4'b1000, 4'h0, 4'h0);
  endtask

  // Run the scenarios in order and report.
  initial begin
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    bus_if.load       = 1'b0;
    bus_if.digit_data = '0;
    bus_if.dp_mask    = '0;
    bus_if.blank_mask = '0;
    bus_if.blink_mask = '0;
    bus_if.brightness = 2'd3;
    $display("[TB] starting seg_scan_mux bench");
    test_reset();
    test_load_display();
    test_boundary_load();
    test_brightness();
    test_blink();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised scanning driver for a multi-digit common-anode 7-segment display, next generation of the safe's timer/code display path. Accepts per-digit hex nibbles plus decimal-point, blank and blink masks through a double-buffered load port. Scans one digit at a time with anti-ghost dead time and PWM brightness control. Sits in the output subsystem between the FSM/timer formatting logic and the board display pins.

## Interface

Parameters:
- NUM_DIGITS, 8: digits scanned, 2..16.
- SCAN_W, 10: width of the per-digit slot counter; slot length is 2**SCAN_W clk cycles.
- BRIGHT_W, 3: brightness control width, must be less than or equal to SCAN_W.
- BLINK_FRAMES, 64: number of full scan frames per blink half-period, at least 1.
- ANODE_ACTIVE_LOW, 1: 1 drives seg_anode low for the selected digit.
- SEG_ACTIVE_LOW, 1: 1 drives lit segments low.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- load, input, 1: one-cycle strobe that captures all display inputs into the pending buffer.
- digit_data, input, 4*NUM_DIGITS: hex nibble per digit; digit 0 is bits [3:0] and is the rightmost digit.
- dp_mask, input, NUM_DIGITS: decimal point on.
- blank_mask, input, NUM_DIGITS: digit forced dark.
- blink_mask, input, NUM_DIGITS: digit dark during the blink-off phase.
- brightness, input, BRIGHT_W: duty level, sampled live rather than buffered.
- seg_cathode, output, 7: segments a..g, bit 0 = a.
- seg_dp, output, 1: decimal point.
- seg_anode, output, NUM_DIGITS: one-hot digit select, polarity per ANODE_ACTIVE_LOW.
- frame_done, output, 1: one-cycle pulse when the last digit slot ends.

## Operation

- slot_cnt counts 0..2**SCAN_W-1 every clk. At its terminal count, dig_idx advances and wraps from NUM_DIGITS-1 to 0.
- A wrap of dig_idx is the frame boundary:
  - frame_done pulses.
  - The pending buffer is copied to the active buffer.
  - frame_cnt increments. When it reaches BLINK_FRAMES-1 it clears and blink_phase toggles.
- A load writes the pending buffer.
  - If load and the frame boundary occur in the same cycle, active takes the old pending contents and pending takes the new data. The new data is displayed one frame later.
- Digit dig_idx is lit only when all of the following hold:
  - slot_cnt is not 0 (a one-cycle dead time at each slot start).
  - blank is clear for that digit.
  - It is not the case that blink is set and blink_phase is 1.
  - The PWM gate is open: the top BRIGHT_W bits of slot_cnt are less than brightness, or brightness is all ones (always on).
- brightness = 0 keeps every digit dark.
- When a digit is unlit, seg_anode is all-inactive and seg_cathode/seg_dp are inactive.
- When a digit is lit, seg_cathode is the hex decode of its active nibble (0-F, standard pattern) and seg_dp is its dp bit, with polarity per SEG_ACTIVE_LOW.
- All pin outputs are registered, so no combinational path exists from inputs to pins.

## Timing

- Reset (rst low, asynchronous) values:
  - seg_anode and seg_cathode/seg_dp all inactive; frame_done 0.
  - slot_cnt, dig_idx, frame_cnt and blink_phase 0.
  - Both buffers cleared with blank_mask all ones, so the display stays dark until a load plus a frame boundary.
- Pin outputs lag the internal slot_cnt/dig_idx state by 1 cycle.
- Latency from load to the new value visible on a digit: up to (NUM_DIGITS*2**SCAN_W + 1) cycles.
- frame_done is asserted in the cycle in which dig_idx wraps to 0, concurrent with the active-buffer update.
- A change to brightness takes effect 1 cycle after it changes.
- A reset asserted mid-frame immediately returns the block to the full reset state. Pending data is discarded.

## Structure

- Shared package seg_pkg:
  - Segment pattern constants for 0-F.
  - SEG_BLANK.
  - Typedef for the display buffer record (data, dp, blank, blink).
- Sub-module hex_to_7seg: purely combinational, 4-bit input to 7-bit active-high pattern. Polarity inversion is applied in seg_scan_mux.
- The FSM for scanning is implicit in slot_cnt/dig_idx; no separate state enum.

## Test plan

- All tests use NUM_DIGITS=4, SCAN_W=4, BRIGHT_W=2, BLINK_FRAMES=2.
- Reset, then hold with no load: seg_anode = 4'b1111 and seg_cathode = 7'h7F for 3 frames; frame_done pulses every 64 cycles.
- Load digit_data=16'h1234, blank=0, brightness=3, then wait for a frame boundary:
  - Digit 0 shows pattern "4" (seg_cathode=7'b1100110 inverted) with anode 4'b1110.
  - The anode stays inactive on slot_cnt=0 of every slot.
- Load in the exact frame-boundary cycle: the old pending value is displayed for one frame, and the new value appears from the next frame onward.
- brightness=1: each digit's anode is active for slot_cnt 1..3 only, i.e. 3 of 16 cycles. brightness=0 keeps all anodes dark.
- blink_mask=4'b0010: digit 1 is dark for 2 frames and lit for 2 frames alternately; the other digits are unaffected.
- Assert rst mid-slot for digit 2: outputs go inactive in the same cycle. After release the display stays dark until a new load plus a boundary.
